// File: rtl/mm_job_sequencer.sv
// Job controller for the matrix-multiply subsystem: streams host words into MemA/MemB,
// pulses core reset and Go, waits for Done under a timeout, and returns the latched product.
module mm_job_sequencer #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 1,
  parameter int WORDS   = 2,
  parameter int RES_W   = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] In_data,
  output logic [ADDR_W-1:0] M_Addrb,
  output logic [DATA_W-1:0] M_dib,
  output logic              MA_enb,
  output logic              MA_web,
  output logic              MB_enb,
  output logic              MB_web,
  output logic              Rst_Core,
  output logic              Go,
  input  logic              Done,
  input  logic [RES_W-1:0]  Mult_out,
  output logic              Res_valid,
  input  logic              Res_ready,
  output logic [RES_W-1:0]  Res_data,
  output logic              Busy,
  output logic              Err
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(WORDS - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_A,
    S_LOAD_B,
    S_GO,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  cnt, cnt_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic               err, err_nx;
  logic [RES_W-1:0]   res_q, res_nx;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      timer <= '0;
      err   <= 1'b0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      timer <= timer_nx;
      err   <= err_nx;
      res_q <= res_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    timer_nx  = timer;
    err_nx    = err;
    res_nx    = res_q;
    In_ready  = 1'b0;
    MA_enb    = 1'b0;
    MA_web    = 1'b0;
    MB_enb    = 1'b0;
    MB_web    = 1'b0;
    Rst_Core  = 1'b0;
    Go        = 1'b0;
    Res_valid = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nx = S_CLR;
          err_nx   = 1'b0;
        end
      end
      S_CLR: begin
        Rst_Core = 1'b1;
        cnt_nx   = '0;
        state_nx = S_LOAD_A;
      end
      S_LOAD_A: begin
        In_ready = 1'b1;
        MA_enb   = In_valid;
        MA_web   = In_valid;
        if (In_valid) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = S_LOAD_B;
          end else begin
            cnt_nx = cnt + ADDR_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        In_ready = 1'b1;
        MB_enb   = In_valid;
        MB_web   = In_valid;
        if (In_valid) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = S_GO;
          end else begin
            cnt_nx = cnt + ADDR_W'(1);
          end
        end
      end
      S_GO: begin
        Go       = 1'b1;
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Done is checked first so it wins over a coincident timeout
        if (Done) begin
          res_nx   = Mult_out;
          state_nx = S_RESULT;
        end else if (timer == TMR_LAST) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      S_RESULT: begin
        Res_valid = 1'b1;
        if (Res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign M_Addrb  = cnt;
  assign M_dib    = In_data;
  assign Busy     = (state != S_IDLE);
  assign Err      = err;
  assign Res_data = res_q;

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Randomized bench for mm_job_sequencer: SRAM/core models plus a job-level reference
// derived from word counts, core latency and the timeout rule.
module tb_mm_job_sequencer;

  localparam int DW = 128;
  localparam int AW = 1;
  localparam int WD = 2;
  localparam int RW = 512;
  localparam int TO = 16;

  logic          Clk, Rst, Start, In_valid, In_ready;
  logic [DW-1:0] In_data, M_dib;
  logic [AW-1:0] M_Addrb;
  logic          MA_enb, MA_web, MB_enb, MB_web, Rst_Core, Go, Done;
  logic [RW-1:0] Mult_out, Res_data;
  logic          Res_valid, Res_ready, Busy, Err;

  mm_job_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .WORDS(WD), .RES_W(RW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .In_valid(In_valid), .In_ready(In_ready),
    .In_data(In_data), .M_Addrb(M_Addrb), .M_dib(M_dib), .MA_enb(MA_enb),
    .MA_web(MA_web), .MB_enb(MB_enb), .MB_web(MB_web), .Rst_Core(Rst_Core),
    .Go(Go), .Done(Done), .Mult_out(Mult_out), .Res_valid(Res_valid),
    .Res_ready(Res_ready), .Res_data(Res_data), .Busy(Busy), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // core model: Done pulses core_lat cycles after Go; core_lat == 0 means never
  int core_lat = 0;
  int cd = 0;
  always @(posedge Clk) begin
    if (Go) cd <= core_lat;
    else if (cd > 0) cd <= cd - 1;
  end
  assign Done = (cd == 1);

  // SRAM models and activity counters
  logic [DW-1:0] mem_a [WD];
  logic [DW-1:0] mem_b [WD];
  int wr_a = 0, wr_b = 0, rc_hi = 0, go_hi = 0, ovl = 0, bad_en = 0;
  always @(posedge Clk) begin
    if (MA_enb && MA_web) begin mem_a[M_Addrb] <= M_dib; wr_a <= wr_a + 1; end
    if (MB_enb && MB_web) begin mem_b[M_Addrb] <= M_dib; wr_b <= wr_b + 1; end
    if (Rst_Core) rc_hi <= rc_hi + 1;
    if (Go) go_hi <= go_hi + 1;
    if (MA_enb && MB_enb) ovl <= ovl + 1;
    if ((MA_enb || MB_enb) && !In_valid) bad_en <= bad_en + 1;
  end

  logic [DW-1:0] jw [2*WD];

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_res();
    logic [RW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < RW / 32; i++) r = {r[RW-33:0], 32'($urandom)};
    return r;
  endfunction

  // Drive words jw[first..first+count-1]; mode 0 back-to-back, 1 alternating gaps, 2 random gaps
  task automatic load_words(input int first, input int count, input int mode);
    int gap, guard;
    for (int i = first; i < first + count; i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 2));
      repeat (gap) begin
        In_valid = 1'b0;
        In_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge Clk);
      end
      In_valid = 1'b1;
      In_data  = jw[i];
      guard = 0;
      while (!In_ready && guard < 20) begin
        @(negedge Clk);
        guard++;
      end
      check("in_ready", In_ready, 1'b1);
      @(negedge Clk);
    end
    In_valid = 1'b0;
    In_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic start_job();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("err_cleared_on_start", Err, 1'b0);
    check("busy_after_start", Busy, 1'b1);
    check("rst_core_pulse", Rst_Core, 1'b1);
  endtask

  task automatic run_job(input int lat, input int mode, input logic [RW-1:0] res, input int hold);
    int n, wa0, wb0, rc0, go0, ov0, bd0;
    for (int i = 0; i < 2 * WD; i++) jw[i] = {$urandom, $urandom, $urandom, $urandom};
    core_lat = lat;
    Mult_out = res;
    wa0 = wr_a; wb0 = wr_b; rc0 = rc_hi; go0 = go_hi; ov0 = ovl; bd0 = bad_en;
    start_job();
    load_words(0, 2 * WD, mode);
    check("go_after_load", Go, 1'b1);
    n = 0;
    while (!Res_valid && !Err && n < TO + 40) begin
      @(negedge Clk);
      n++;
    end
    if (lat < 1 || lat > TO) begin
      check("timeout_cycles", n, TO + 1);
      check("err_set", Err, 1'b1);
      check("busy_low_on_err", Busy, 1'b0);
      check("no_valid_on_err", Res_valid, 1'b0);
    end else begin
      check("result_latency", n, lat + 1);
      check("res_data", Res_data, res);
      check("no_err", Err, 1'b0);
      for (int k = 0; k < hold; k++) begin
        Mult_out = rand_res();
        Start = (k % 3 == 0);
        @(negedge Clk);
        check("hold_valid", Res_valid, 1'b1);
        check("hold_data", Res_data, res);
      end
      Start = 1'b0;
      Res_ready = 1'b1;
      @(negedge Clk);
      Res_ready = 1'b0;
      check("valid_cleared", Res_valid, 1'b0);
      check("idle_after_result", Busy, 1'b0);
    end
    for (int i = 0; i < WD; i++) begin
      check("mem_a", mem_a[i], jw[i]);
      check("mem_b", mem_b[i], jw[WD + i]);
    end
    check("writes_a", wr_a - wa0, WD);
    check("writes_b", wr_b - wb0, WD);
    check("rst_core_cycles", rc_hi - rc0, 1);
    check("go_cycles", go_hi - go0, 1);
    check("ma_mb_overlap", ovl - ov0, 0);
    check("enable_without_valid", bad_en - bd0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, In_ready, 1'b0);
    check({tag, "_enables"}, {MA_enb, MA_web, MB_enb, MB_web}, 4'b0);
    check({tag, "_strobes"}, {Rst_Core, Go, Res_valid}, 3'b0);
    check({tag, "_busy_err"}, {Busy, Err}, 2'b0);
    check({tag, "_res_data"}, Res_data, '0);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; In_valid = 1'b0; In_data = '0;
    Res_ready = 1'b0; Mult_out = '0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;
    @(negedge Clk);

    // nominal job, back-to-back words, Done 5 cycles after Go
    run_job(5, 0, {16'hDEAD, 494'd0, 2'b01}, 0);
    // alternating In_valid during loads
    run_job(7, 1, rand_res(), 1);
    // core never finishes: timeout, then the next Start clears Err
    run_job(0, 0, rand_res(), 0);
    repeat (3) @(negedge Clk);
    check("err_sticky", Err, 1'b1);
    // long Res_ready stall with ignored Start pulses
    run_job(3, 2, rand_res(), 20);

    // reset in LOAD_B after B0
    for (int i = 0; i < 2 * WD; i++) jw[i] = {$urandom, $urandom, $urandom, $urandom};
    core_lat = 4;
    start_job();
    load_words(0, WD + 1, 0);
    #2 Rst = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    run_job(4, 0, rand_res(), 2);

    // Done on the final timeout cycle
    run_job(TO, 0, rand_res(), 0);

    // randomized jobs, including late Done that must time out
    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(1, TO + 4)), 2, rand_res(), int'($urandom_range(0, 5)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
